// File: rtl/cache_line_fill.sv
// cache_line_fill: line-fill engine in front of the per-way synchronous-read
// data RAM of the L1 cache. It requests one line from next-level memory on a
// miss, writes each returned beat into the RAM, and passes the cache read
// address through to the RAM while idle.
module cache_line_fill #(
    parameter int unsigned AWIDTH  = 3,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned OWIDTH  = 1,
    parameter int unsigned MAWIDTH = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     fill_req,
    input  logic [AWIDTH-OWIDTH-1:0] fill_line,
    input  logic [MAWIDTH-1:0]       fill_maddr,
    output logic                     fill_busy,
    output logic                     fill_done,
    output logic                     fill_err,
    output logic                     mem_req,
    output logic [MAWIDTH-1:0]       mem_addr,
    input  logic                     mem_ack,
    input  logic                     mem_rvalid,
    input  logic [DWIDTH-1:0]        mem_rdata,
    input  logic [AWIDTH-1:0]        rd_addr,
    output logic                     rd_stall,
    output logic [AWIDTH-1:0]        ram_addr,
    output logic [DWIDTH-1:0]        ram_din,
    output logic                     ram_we
);

    localparam int unsigned LWIDTH = AWIDTH - OWIDTH;
    localparam int unsigned ALIGN  = OWIDTH + $clog2(DWIDTH / 8);
    localparam int unsigned TWIDTH = $clog2(TIMEOUT);

    // Last word of a line is the all-ones word offset.
    localparam logic [OWIDTH-1:0]  CNT_LAST   = '1;
    localparam logic [TWIDTH-1:0]  TMO_LAST   = TWIDTH'(TIMEOUT - 1);
    localparam logic [MAWIDTH-1:0] ALIGN_MASK = ~((MAWIDTH'(1) << ALIGN) - MAWIDTH'(1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [LWIDTH-1:0]   line_q;
    logic [OWIDTH-1:0]   cnt_q;
    logic [TWIDTH-1:0]   tmo_q;
    logic [AWIDTH-1:0]   wr_addr_q;

    logic                start_fill;
    logic                beat_fire;
    logic                last_beat;
    logic                abort_fill;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle event decode.
    always_comb begin
        state_d    = state_q;
        start_fill = 1'b0;
        beat_fire  = 1'b0;
        last_beat  = 1'b0;
        abort_fill = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_req) begin
                    start_fill = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_rvalid) begin
                    beat_fire = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        last_beat = 1'b1;
                        state_d   = S_DONE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    abort_fill = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request latch, beat/timeout counters, registered RAM write port and pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_q    <= '0;
            mem_addr  <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            wr_addr_q <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
        end else begin
            if (start_fill) begin
                line_q   <= fill_line;
                mem_addr <= fill_maddr & ALIGN_MASK;
            end
            if (state_q == S_REQ && mem_ack) begin
                cnt_q <= '0;
                tmo_q <= '0;
            end
            if (state_q == S_FILL) begin
                if (mem_rvalid) begin
                    cnt_q <= cnt_q + OWIDTH'(1);
                    tmo_q <= '0;
                end else begin
                    tmo_q <= tmo_q + TWIDTH'(1);
                end
            end
            ram_we <= beat_fire;
            if (beat_fire) begin
                wr_addr_q <= {line_q, cnt_q};
                ram_din   <= mem_rdata;
            end
            fill_done <= last_beat;
            fill_err  <= abort_fill;
        end
    end

    // Status outputs and RAM address mux.
    always_comb begin
        fill_busy = (state_q != S_IDLE);
        rd_stall  = fill_busy;
        mem_req   = (state_q == S_REQ);
        ram_addr  = (state_q == S_IDLE) ? rd_addr : wr_addr_q;
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: scoreboard bench for cache_line_fill. Expected RAM
// writes are queued when beats are driven and compared when ram_we appears.
module tb_cache_line_fill;

    localparam int unsigned AW  = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned OW  = 1;
    localparam int unsigned MAW = 32;
    localparam int unsigned TMO = 16;

    logic                clock;
    logic                reset_n;
    logic                fill_req;
    logic [AW-OW-1:0]    fill_line;
    logic [MAW-1:0]      fill_maddr;
    logic                fill_busy;
    logic                fill_done;
    logic                fill_err;
    logic                mem_req;
    logic [MAW-1:0]      mem_addr;
    logic                mem_ack;
    logic                mem_rvalid;
    logic [DW-1:0]       mem_rdata;
    logic [AW-1:0]       rd_addr;
    logic                rd_stall;
    logic [AW-1:0]       ram_addr;
    logic [DW-1:0]       ram_din;
    logic                ram_we;

    int unsigned checks;
    int unsigned failures;
    int unsigned done_cnt;
    int unsigned err_cnt;
    int unsigned wr_cnt;
    int unsigned req_rise;
    logic        mem_req_prev;

    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    cache_line_fill #(
        .AWIDTH (AW),
        .DWIDTH (DW),
        .OWIDTH (OW),
        .MAWIDTH(MAW),
        .TIMEOUT(TMO)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .fill_req  (fill_req),
        .fill_line (fill_line),
        .fill_maddr(fill_maddr),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .fill_err  (fill_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .rd_addr   (rd_addr),
        .rd_stall  (rd_stall),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // Bounded wait for IDLE, then one more cycle so trailing pulses are sampled.
    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && fill_busy; i++) step();
        check(tag, {63'd0, fill_busy}, 64'd0);
        step();
    endtask

    task automatic run_fill(input string tag, input logic [AW-OW-1:0] line,
                            input logic [MAW-1:0] maddr, input int ack_wait,
                            input int gap, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [AW-1:0]  a0;
        logic [MAW-1:0] aligned;
        a0      = {line, 1'b0};
        aligned = maddr & ~32'h7;
        fill_req   = 1'b1;
        fill_line  = line;
        fill_maddr = maddr;
        step();
        fill_req = 1'b0;
        check({tag, "_mem_req"}, {63'd0, mem_req}, 64'd1);
        check({tag, "_mem_addr"}, {32'd0, mem_addr}, {32'd0, aligned});
        check({tag, "_stall"}, {63'd0, rd_stall}, 64'd1);
        repeat (ack_wait) step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        push_beat(a0, d0);
        step();
        if (gap > 0) begin
            mem_rvalid = 1'b0;
            repeat (gap) step();
        end
        push_beat(a0 + 3'd1, d1);
        step();
        mem_rvalid = 1'b0;
        wait_idle({tag, "_idle"}, 20);
    endtask

    // Output monitor: scoreboard pops on every RAM write, pulse accounting.
    initial begin
        mem_req_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                check("done_err_excl", {63'd0, fill_done & fill_err}, 64'd0);
                if (fill_done) done_cnt++;
                if (fill_err) err_cnt++;
                if (mem_req && !mem_req_prev) req_rise++;
                if (ram_we) begin
                    wr_cnt++;
                    if (exp_addr.size() == 0) begin
                        check("wr_unexpected", {63'd0, ram_we}, 64'd0);
                    end else begin
                        check("wr_addr", {61'd0, ram_addr}, {61'd0, exp_addr.pop_front()});
                        check("wr_data", {32'd0, ram_din}, {32'd0, exp_data.pop_front()});
                    end
                end
            end
            mem_req_prev = mem_req;
        end
    end

    initial begin
        int unsigned d0, e0, w0, r0;
        checks = 0; failures = 0;
        done_cnt = 0; err_cnt = 0; wr_cnt = 0; req_rise = 0;
        reset_n = 1'b0; fill_req = 1'b0; fill_line = '0; fill_maddr = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rd_addr = 3'd5;

        // 1: reset state and pass-through
        repeat (2) step();
        check("rst_busy", {63'd0, fill_busy}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_we", {63'd0, ram_we}, 64'd0);
        check("rst_ram_addr", {61'd0, ram_addr}, 64'd5);
        check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_pulses", {62'd0, fill_done, fill_err}, 64'd0);
        reset_n = 1'b1;
        step();
        rd_addr = 3'd3;
        #1;
        check("idle_passthru", {61'd0, ram_addr}, 64'd3);

        // 2: basic fill, ack after 2 cycles, back-to-back beats
        d0 = done_cnt; e0 = err_cnt;
        run_fill("basic", 2'd2, 32'h1004, 2, 0, 32'hAA, 32'hBB);
        check("basic_done", done_cnt - d0, 1);
        check("basic_err", err_cnt - e0, 0);
        check("basic_passthru", {61'd0, ram_addr}, 64'd3);

        // 3: gapped beats, no timeout
        d0 = done_cnt; e0 = err_cnt;
        run_fill("gap", 2'd1, 32'h200C, 0, 3, 32'hCC, 32'hDD);
        check("gap_done", done_cnt - d0, 1);
        check("gap_err", err_cnt - e0, 0);

        // 4: timeout after one beat
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        fill_req = 1'b1; fill_line = 2'd3; fill_maddr = 32'h3000;
        step();
        fill_req = 1'b0; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        push_beat(3'd6, 32'hEE);
        step();
        mem_rvalid = 1'b0;
        repeat (TMO - 1) step();
        check("tmo_busy_before", {63'd0, fill_busy}, 64'd1);
        check("tmo_err_before", {63'd0, fill_err}, 64'd0);
        step();
        check("tmo_err_pulse", {63'd0, fill_err}, 64'd1);
        check("tmo_idle", {63'd0, fill_busy}, 64'd0);
        step();
        check("tmo_err_clear", {63'd0, fill_err}, 64'd0);
        check("tmo_err_cnt", err_cnt - e0, 1);
        check("tmo_done_cnt", done_cnt - d0, 0);
        check("tmo_writes", wr_cnt - w0, 1);

        // 5: ignored events
        d0 = done_cnt; r0 = req_rise; w0 = wr_cnt;
        fill_req = 1'b1; fill_line = 2'd0; fill_maddr = 32'h44;
        step();
        fill_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        step();
        check("ign_mem_addr", {32'd0, mem_addr}, 64'h40);
        mem_rvalid = 1'b0; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        fill_req = 1'b1; fill_line = 2'd3; fill_maddr = 32'h9000;
        push_beat(3'd0, 32'h11);
        step();
        push_beat(3'd1, 32'h22);
        step();
        mem_rvalid = 1'b0; fill_req = 1'b0;
        wait_idle("ign_idle", 20);
        repeat (3) step();
        check("ign_no_rereq", {63'd0, fill_busy}, 64'd0);
        check("ign_req_cnt", req_rise - r0, 1);
        check("ign_writes", wr_cnt - w0, 2);
        check("ign_done", done_cnt - d0, 1);

        // 6: reset mid-FILL, then a clean fill
        d0 = done_cnt; e0 = err_cnt;
        fill_req = 1'b1; fill_line = 2'd1; fill_maddr = 32'h80;
        step();
        fill_req = 1'b0; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        push_beat(3'd2, 32'h55);
        step();
        mem_rvalid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("mrst_busy", {63'd0, fill_busy}, 64'd0);
        check("mrst_pulses", {62'd0, fill_done, fill_err}, 64'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("mrst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        run_fill("post", 2'd2, 32'h100, 1, 0, 32'h66, 32'h77);
        check("post_done", done_cnt - d0, 1);
        check("post_err", err_cnt - e0, 0);

        check("sb_empty", exp_addr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
